pipe_hazard_ctrl: RTL

Hazard controller for the 5-stage pipeline: drives the enable and flush inputs of the PC, IF/ID and ID/EX registers and, optionally, the EX-stage forwarding selects. It detects RAW hazards between the decode stage and the EX/MEM stages. It squashes wrong-path instructions on a taken branch and holds the front of the pipe for the duration of a multi-cycle multiply. It sits beside the decode stage and is the only source of stall/flush control for the pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline.
// It detects RAW hazards between decode and the EX/MEM stages, squashes
// wrong-path instructions on a taken branch, and freezes the front of the
// pipe while a multi-cycle multiply occupies EX.
// Optional feature macro: PIPE_FWD_EN (EX/MEM forwarding, load-use stall only).
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic        UseRs,
  input  logic        UseRt,
  input  logic        MulStart,
  input  logic        eWreg,
  input  logic        eReg2reg,
  input  logic [4:0]  eRd,
  input  logic        mWreg,
  input  logic [4:0]  mRd,
  input  logic        Branch,
  output logic        PcEn,
  output logic        IfidEn,
  output logic        IdexEn,
  output logic        IfidFlush,
  output logic        IdexFlush,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic        Busy,
  output logic [15:0] StallCnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MULWAIT = 1'b1
  } state_t;

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic ex_a, ex_b, mem_a, mem_b;
  logic stall;
  logic pc_en, ifid_en, idex_en, ifid_flush, idex_flush;

  // Source/destination match terms: nonzero destination, stage writes, source used
  always_comb begin
    ex_a  = UseRs & eWreg & (eRd != '0) & (eRd == Rs);
    ex_b  = UseRt & eWreg & (eRd != '0) & (eRd == Rt);
    mem_a = UseRs & mWreg & (mRd != '0) & (mRd == Rs);
    mem_b = UseRt & mWreg & (mRd != '0) & (mRd == Rt);
  end

`ifdef PIPE_FWD_EN
  // With forwarding only a load in EX cannot be bypassed in time
  always_comb begin
    stall = eReg2reg & (ex_a | ex_b);
  end

  // Operand source select: EX result has priority over MEM result
  always_comb begin
    FwdA = 2'd0;
    FwdB = 2'd0;
    if (!Clr) begin
      if (ex_a)       FwdA = 2'd1;
      else if (mem_a) FwdA = 2'd2;
      if (ex_b)       FwdB = 2'd1;
      else if (mem_b) FwdB = 2'd2;
    end
  end
`else
  logic unused_reg2reg;

  // Without forwarding any in-flight producer blocks the dependent instruction
  always_comb begin
    stall         = ex_a | ex_b | mem_a | mem_b;
    unused_reg2reg = eReg2reg;
  end

  // Operands always come from the register file
  always_comb begin
    FwdA = '0;
    FwdB = '0;
  end
`endif

  // Next-state and enable/flush decode; branch beats stall beats multiply
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (Branch) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (stall) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (MulStart) begin
          cnt_d   = MUL_LOAD;
          state_d = MULWAIT;
        end
      end
      MULWAIT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State, multiply counter and stall counter registers
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces a bubble into both front registers and holds the PC
  always_comb begin
    PcEn      = pc_en & ~Clr;
    IfidEn    = ifid_en & ~Clr;
    IdexEn    = idex_en & ~Clr;
    IfidFlush = ifid_flush | Clr;
    IdexFlush = idex_flush | Clr;
    Busy      = (state_q == MULWAIT);
    StallCnt  = stall_cnt_q;
  end

endmodule
